// File: rtl/stream_writer_arbiter_pkg.sv
// Shared types and defaults for the stream writer arbiter.
// No logic of its own. Defines the FSM state encoding and the default sizing.
// The state values are fixed so that waveforms and the bench read the same numbers.
package stream_writer_arbiter_pkg;

    localparam int DEF_NUM_INPUTS = 4;
    localparam int DEF_WIDTH      = 32;
    localparam int DEF_SEL_W      = 2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCEPT = 2'd1,
        ST_SEND   = 2'd2
    } state_e;

endpackage

// File: rtl/stream_writer_arbiter_picker.sv
// rr_priority_picker: round-robin selection of one requester.
// Latency: purely combinational, 0 cycles.
// Backpressure: none. The caller decides when to act on grant_o.
// Ports: req_i (request vector), last_i (previous grant),
//        any_o (some request is set), grant_o (chosen index).
module rr_priority_picker #(
    parameter int NUM_INPUTS = 4,
    parameter int SEL_W      = 2
) (
    input  logic [NUM_INPUTS-1:0] req_i,
    input  logic [SEL_W-1:0]      last_i,
    output logic                  any_o,
    output logic [SEL_W-1:0]      grant_o
);

    int idx;

    // Search last+1, last+2, ... with wrap. The loop runs from the farthest
    // offset down to the nearest, so the nearest set request is assigned last
    // and wins. This is the rotate / encode / un-rotate scheme written as a
    // single pass. It also works when NUM_INPUTS is not a power of two.
    always_comb begin
        any_o   = 1'b0;
        grant_o = '0;
        idx     = 0;
        for (int i = NUM_INPUTS; i >= 1; i--) begin
            idx = (int'(last_i) + i) % NUM_INPUTS;
            if (req_i[idx[SEL_W-1:0]]) begin
                any_o   = 1'b1;
                grant_o = idx[SEL_W-1:0];
            end
        end
    end

endmodule

// File: rtl/stream_writer_arbiter.sv
// Round-robin arbiter that funnels NUM_INPUTS stb/ack producers into one sink.
// Latency: grant 1 cycle after stb is seen, word registered 1 cycle later; minimum 3 cycles/word.
// Backpressure: holds one word in SEND until out_z_ack_i. No grant is issued while a word is held.
// Ports: clk, rst_n (async, active-low); in_data_i/in_stb_i/in_ack_o (producers, packed
//        by index); out_z_o/out_z_src_o/out_z_stb_o/out_z_ack_i (sink).
module stream_writer_arbiter
    import stream_writer_arbiter_pkg::*;
#(
    parameter int NUM_INPUTS = DEF_NUM_INPUTS,
    parameter int WIDTH      = DEF_WIDTH,
    parameter int SEL_W      = DEF_SEL_W
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_INPUTS*WIDTH-1:0] in_data_i,
    input  logic [NUM_INPUTS-1:0]       in_stb_i,
    output logic [NUM_INPUTS-1:0]       in_ack_o,
    output logic [WIDTH-1:0]            out_z_o,
    output logic [SEL_W-1:0]            out_z_src_o,
    output logic                        out_z_stb_o,
    input  logic                        out_z_ack_i
);

    state_e                  state_q,  state_d;
    logic [SEL_W-1:0]        grant_q,  grant_d;
    logic [SEL_W-1:0]        last_q,   last_d;
    logic [NUM_INPUTS-1:0]   in_ack_q, in_ack_d;
    logic [WIDTH-1:0]        out_z_q,  out_z_d;
    logic [SEL_W-1:0]        src_q,    src_d;
    logic                    stb_q,    stb_d;

    logic                    pick_any;
    logic [SEL_W-1:0]        pick_grant;

    rr_priority_picker #(
        .NUM_INPUTS (NUM_INPUTS),
        .SEL_W      (SEL_W)
    ) u_picker (
        .req_i   (in_stb_i),
        .last_i  (last_q),
        .any_o   (pick_any),
        .grant_o (pick_grant)
    );

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        last_d   = last_q;
        in_ack_d = in_ack_q;
        out_z_d  = out_z_q;
        src_d    = src_q;
        stb_d    = stb_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_any) begin
                    grant_d              = pick_grant;
                    in_ack_d             = '0;
                    in_ack_d[pick_grant] = 1'b1;
                    state_d              = ST_ACCEPT;
                end
            end
            ST_ACCEPT: begin
                // The grant stays with this input even if its stb drops.
                // Other inputs are not considered again until IDLE.
                if (in_stb_i[grant_q]) begin
                    out_z_d  = in_data_i[int'(grant_q)*WIDTH +: WIDTH];
                    src_d    = grant_q;
                    in_ack_d = '0;
                    stb_d    = 1'b1;
                    last_d   = grant_q;
                    state_d  = ST_SEND;
                end
            end
            ST_SEND: begin
                if (out_z_ack_i) begin
                    stb_d   = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                in_ack_d = '0;
                stb_d    = 1'b0;
                state_d  = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            grant_q  <= '0;
            // Start as if the highest input was served last, so input 0 goes first.
            last_q   <= SEL_W'(NUM_INPUTS - 1);
            in_ack_q <= '0;
            out_z_q  <= '0;
            src_q    <= '0;
            stb_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            last_q   <= last_d;
            in_ack_q <= in_ack_d;
            out_z_q  <= out_z_d;
            src_q    <= src_d;
            stb_q    <= stb_d;
        end
    end

    assign in_ack_o    = in_ack_q;
    assign out_z_o     = out_z_q;
    assign out_z_src_o = src_q;
    assign out_z_stb_o = stb_q;

endmodule

// File: tb/tb_stream_writer_arbiter.sv
// Directed and randomized bench for stream_writer_arbiter.
// Inputs are driven 1ns after each rising edge, and outputs are sampled at the same point.
// The random phase checks delivered words, one-hot acks and round-robin wait bounds.
module tb_stream_writer_arbiter;

    localparam int N = 4;
    localparam int W = 32;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [N*W-1:0]   in_data = '0;
    logic [N-1:0]     in_stb = '0;
    logic [N-1:0]     in_ack;
    logic [W-1:0]     out_z;
    logic [1:0]       out_z_src;
    logic             out_z_stb;
    logic             out_z_ack = 1'b0;

    int total = 0;
    int bad   = 0;

    logic [23:0]      seq [N];
    int               wait_cnt [N];
    logic [35:0]      expq [$];
    int               produced = 0;
    int               delivered = 0;

    stream_writer_arbiter #(.NUM_INPUTS(N), .WIDTH(W), .SEL_W(2)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_data_i   (in_data),
        .in_stb_i    (in_stb),
        .in_ack_o    (in_ack),
        .out_z_o     (out_z),
        .out_z_src_o (out_z_src),
        .out_z_stb_o (out_z_stb),
        .out_z_ack_i (out_z_ack)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // One cycle of random producer and sink activity with scoreboard bookkeeping.
    // When allow_new is 0, producers only finish words that are already presented.
    task automatic random_cycle(input bit allow_new);
        logic [N-1:0] fire_in;
        logic [N-1:0] stb_snap;
        logic [N-1:0] prev_ack;
        logic         fire_out;
        logic [W-1:0] oz;
        logic [1:0]   osrc;
        logic [35:0]  item;
        fire_in  = in_stb & in_ack;
        stb_snap = in_stb;
        prev_ack = in_ack;
        fire_out = out_z_stb & out_z_ack;
        oz       = out_z;
        osrc     = out_z_src;
        for (int i = 0; i < N; i++) begin
            if (fire_in[i]) begin
                expq.push_back({4'(i), in_data[i*W +: W]});
                produced++;
            end
        end
        tick;
        chk("onehot", 32'($countones(in_ack) <= 1), 32'd1);
        chk("ack_while_stb", {31'b0, (|in_ack) & out_z_stb}, 32'd0);
        if (fire_out) begin
            delivered++;
            if (expq.size() == 0) begin
                chk("sb_unexpected_word", 32'd1, 32'd0);
            end else begin
                item = expq.pop_front();
                chk("sb_data", oz, item[31:0]);
                chk("sb_src", {30'b0, osrc}, {28'b0, item[35:32]});
            end
        end
        if (prev_ack == '0 && in_ack != '0) begin
            for (int j = 0; j < N; j++) begin
                if (in_ack[j]) begin
                    wait_cnt[j] = 0;
                end else if (stb_snap[j]) begin
                    wait_cnt[j]++;
                    chk("fair_wait", 32'(wait_cnt[j] <= N), 32'd1);
                end
            end
        end
        for (int i = 0; i < N; i++) begin
            if (fire_in[i]) begin
                seq[i]    = seq[i] + 24'd1;
                in_stb[i] = allow_new && ($urandom_range(0, 3) != 0);
            end else if (!in_stb[i]) begin
                in_stb[i] = allow_new && ($urandom_range(0, 2) == 0);
            end
            in_data[i*W +: W] = {8'(i), seq[i]};
        end
        out_z_ack = allow_new ? 1'($urandom_range(0, 1)) : 1'b1;
    endtask

    initial begin
        // Reset state
        #12;
        chk("rst_in_ack", {28'b0, in_ack}, 32'd0);
        chk("rst_stb", {31'b0, out_z_stb}, 32'd0);
        chk("rst_out_z", out_z, 32'd0);
        chk("rst_src", {30'b0, out_z_src}, 32'd0);
        rst_n = 1'b1;
        tick;

        // Single request from input 2
        in_data[2*W +: W] = 32'h0000_00A5;
        in_stb = 4'b0100;
        out_z_ack = 1'b1;
        tick;
        chk("t1_grant", {28'b0, in_ack}, 32'h4);
        chk("t1_stb_lo", {31'b0, out_z_stb}, 32'd0);
        tick;
        chk("t1_ack_drop", {28'b0, in_ack}, 32'd0);
        chk("t1_stb", {31'b0, out_z_stb}, 32'd1);
        chk("t1_out_z", out_z, 32'h0000_00A5);
        chk("t1_src", {30'b0, out_z_src}, 32'd2);
        in_stb = 4'b0000;
        tick;
        chk("t1_stb_done", {31'b0, out_z_stb}, 32'd0);

        // All inputs requesting from a fresh reset: grants go 0,1,2,3,0,1
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        for (int i = 0; i < N; i++) in_data[i*W +: W] = 32'(100 + i);
        in_stb = 4'b1111;
        for (int k = 0; k < 6; k++) begin
            tick;
            chk("t2_grant", {28'b0, in_ack}, 32'(1 << (k % 4)));
            tick;
            chk("t2_src", {30'b0, out_z_src}, 32'(k % 4));
            chk("t2_out_z", out_z, 32'(100 + k % 4));
            chk("t2_stb", {31'b0, out_z_stb}, 32'd1);
            tick;
            chk("t2_stb_done", {31'b0, out_z_stb}, 32'd0);
        end

        // Sink backpressure while holding the word from input 2
        out_z_ack = 1'b0;
        tick;
        chk("t3_grant", {28'b0, in_ack}, 32'h4);
        tick;
        chk("t3_out_z", out_z, 32'd102);
        chk("t3_src", {30'b0, out_z_src}, 32'd2);
        for (int k = 0; k < 10; k++) begin
            tick;
            chk("t3_hold_stb", {31'b0, out_z_stb}, 32'd1);
            chk("t3_hold_z", out_z, 32'd102);
            chk("t3_no_ack", {28'b0, in_ack}, 32'd0);
        end
        out_z_ack = 1'b1;
        tick;
        chk("t3_release", {31'b0, out_z_stb}, 32'd0);
        tick;
        chk("t3_next_grant", {28'b0, in_ack}, 32'h8);
        tick;
        chk("t3_next_src", {30'b0, out_z_src}, 32'd3);
        in_stb = 4'b0000;
        tick;
        tick;

        // Late producer on input 1: the grant is held and nobody else is served
        in_data[1*W +: W] = 32'h0000_1111;
        in_stb = 4'b0010;
        tick;
        chk("t4_grant", {28'b0, in_ack}, 32'h2);
        in_stb = 4'b0101;
        for (int k = 0; k < 3; k++) begin
            tick;
            chk("t4_hold_ack", {28'b0, in_ack}, 32'h2);
            chk("t4_no_stb", {31'b0, out_z_stb}, 32'd0);
        end
        in_data[1*W +: W] = 32'h0000_BEEF;
        in_stb = 4'b0111;
        tick;
        chk("t4_out_z", out_z, 32'h0000_BEEF);
        chk("t4_src", {30'b0, out_z_src}, 32'd1);
        chk("t4_ack_drop", {28'b0, in_ack}, 32'd0);
        in_stb = 4'b0101;
        tick;
        chk("t4_done", {31'b0, out_z_stb}, 32'd0);
        tick;
        chk("t4_next_grant", {28'b0, in_ack}, 32'h4);
        out_z_ack = 1'b0;
        tick;
        chk("t5_in_send", {31'b0, out_z_stb}, 32'd1);
        tick;

        // Asynchronous reset while a word is held
        #3;
        rst_n = 1'b0;
        #1;
        chk("t5_stb_async", {31'b0, out_z_stb}, 32'd0);
        chk("t5_ack_async", {28'b0, in_ack}, 32'd0);
        chk("t5_z_async", out_z, 32'd0);
        chk("t5_src_async", {30'b0, out_z_src}, 32'd0);
        #1;
        rst_n = 1'b1;
        out_z_ack = 1'b1;
        tick;
        chk("t5_first_grant", {28'b0, in_ack}, 32'h1);
        tick;
        chk("t5_out_z", out_z, 32'd100);
        chk("t5_src", {30'b0, out_z_src}, 32'd0);
        in_stb = 4'b0000;
        tick;
        tick;

        // Random traffic with scoreboard, then drain
        for (int i = 0; i < N; i++) begin
            seq[i] = '0;
            wait_cnt[i] = 0;
        end
        for (int c = 0; c < 10000; c++) random_cycle(1'b1);
        for (int c = 0; c < 200; c++) random_cycle(1'b0);
        chk("drain_stb", {28'b0, in_stb}, 32'd0);
        chk("drain_out_stb", {31'b0, out_z_stb}, 32'd0);
        chk("drain_queue", 32'(expq.size()), 32'd0);
        chk("drain_count", 32'(delivered), 32'(produced));
        chk("traffic_seen", 32'(produced > 500), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
